// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state codes,
// requester IDs and default address/data widths.
package mem_arb_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selection between fetch and data requesters.
// Purely combinational; the caller registers the result.
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic i_if_req,
    input  logic i_d_req,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_valid
);

    // On contention, either alternate away from the last winner or let data win.
    always_comb begin
        o_valid = i_if_req | i_d_req;
        o_grant = REQ_IF;
        if (i_if_req && i_d_req) begin
            o_grant = ROUND_ROBIN ? ~i_last_grant : REQ_D;
        end else if (i_d_req) begin
            o_grant = REQ_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port memory between the instruction fetch unit and the
// load/store datapath, one access at a time, with registered strobes/acks.
//
// state  | meaning
// IDLE   | waiting; sample requests, pick a winner, drive one strobe low
// ACCESS | memory performs the access on the negedge of this cycle
// DONE   | winner's ack is high; requests ignored
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = AW_DEF,
    parameter int DW          = DW_DEF,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic          clk,
    input  logic          proc_rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    output logic          mem_write_n,
    output logic          mem_read_n,
    input  logic [DW-1:0] mem_out,
    output logic          busy
);

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic          r_gnt;
    logic          r_is_write;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_in;
    logic          r_write_n;
    logic          r_read_n;
    logic          r_if_ack;
    logic          r_d_ack;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_gnt;
    logic          w_gnt_valid;
    logic          w_d_write;

    rr_arb2 #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_rr_arb2 (
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_gnt),
        .o_valid      (w_gnt_valid)
    );

    assign w_d_write = (w_gnt == REQ_D) && d_we;

    // Access sequencer: latch the winner, strobe for one cycle, then ack for one cycle.
    // Reset drops the strobes asynchronously so an in-flight write never lands.
    always_ff @(posedge clk or negedge proc_rst) begin
        if (!proc_rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= REQ_D;
            r_gnt        <= REQ_IF;
            r_is_write   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_in     <= '0;
            r_write_n    <= 1'b1;
            r_read_n     <= 1'b1;
            r_if_ack     <= 1'b0;
            r_d_ack      <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt        <= w_gnt;
                        r_last_grant <= w_gnt;
                        r_is_write   <= w_d_write;
                        r_mem_addr   <= (w_gnt == REQ_D) ? d_addr : if_addr;
                        if (w_d_write) begin
                            r_mem_in  <= d_wdata;
                            r_write_n <= 1'b0;
                        end else begin
                            r_read_n  <= 1'b0;
                        end
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_write_n <= 1'b1;
                    r_read_n  <= 1'b1;
                    if (r_gnt == REQ_D) begin
                        r_d_ack <= 1'b1;
                        if (!r_is_write) begin
                            r_d_rdata <= mem_out;
                        end
                    end else begin
                        r_if_ack   <= 1'b1;
                        r_if_rdata <= mem_out;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_write_n <= 1'b1;
                    r_read_n  <= 1'b1;
                    r_if_ack  <= 1'b0;
                    r_d_ack   <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack      = r_if_ack;
    assign if_rdata    = r_if_rdata;
    assign d_ack       = r_d_ack;
    assign d_rdata     = r_d_rdata;
    assign mem_addr    = r_mem_addr;
    assign mem_in      = r_mem_in;
    assign mem_write_n = r_write_n;
    assign mem_read_n  = r_read_n;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: two arbiter instances (round-robin and data-priority),
// each with its own negedge-sampled 32x16 memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic proc_rst;
    always #5 clk = ~clk;

    // round-robin instance
    logic        a_if_req, a_d_req, a_d_we;
    logic [4:0]  a_if_addr, a_d_addr;
    logic [15:0] a_d_wdata;
    logic        a_if_ack, a_d_ack, a_mem_write_n, a_mem_read_n, a_busy;
    logic [15:0] a_if_rdata, a_d_rdata, a_mem_in;
    logic [4:0]  a_mem_addr;
    logic [15:0] a_mem_out = '0;
    logic [15:0] mem_a [32];
    logic        a_seeded = 1'b0;

    // data-priority instance
    logic        b_if_req, b_d_req, b_d_we;
    logic [4:0]  b_if_addr, b_d_addr;
    logic [15:0] b_d_wdata;
    logic        b_if_ack, b_d_ack, b_mem_write_n, b_mem_read_n, b_busy;
    logic [15:0] b_if_rdata, b_d_rdata, b_mem_in;
    logic [4:0]  b_mem_addr;
    logic [15:0] b_mem_out = '0;
    logic [15:0] mem_b [32];
    logic        b_seeded = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    mem_port_arbiter #(.AW(5), .DW(16), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .proc_rst(proc_rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_ack(a_d_ack), .d_rdata(a_d_rdata),
        .mem_addr(a_mem_addr), .mem_in(a_mem_in), .mem_write_n(a_mem_write_n),
        .mem_read_n(a_mem_read_n), .mem_out(a_mem_out), .busy(a_busy)
    );

    mem_port_arbiter #(.AW(5), .DW(16), .ROUND_ROBIN(1'b0)) u_dp (
        .clk(clk), .proc_rst(proc_rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_in(b_mem_in), .mem_write_n(b_mem_write_n),
        .mem_read_n(b_mem_read_n), .mem_out(b_mem_out), .busy(b_busy)
    );

    // memory model A: word 4 = 1111, others B000+addr
    always @(negedge clk) begin
        if (!a_seeded) begin
            for (int i = 0; i < 32; i++) mem_a[i] <= (i == 4) ? 16'h1111 : 16'hB000 + 16'(i);
            a_seeded <= 1'b1;
        end else begin
            if (!a_mem_write_n) mem_a[a_mem_addr] <= a_mem_in;
            if (!a_mem_read_n)  a_mem_out <= mem_a[a_mem_addr];
        end
    end

    // memory model B: same contents
    always @(negedge clk) begin
        if (!b_seeded) begin
            for (int i = 0; i < 32; i++) mem_b[i] <= (i == 4) ? 16'h1111 : 16'hB000 + 16'(i);
            b_seeded <= 1'b1;
        end else begin
            if (!b_mem_write_n) mem_b[b_mem_addr] <= b_mem_in;
            if (!b_mem_read_n)  b_mem_out <= mem_b[b_mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        proc_rst  = 1'b0;
        a_if_req  = 1'($urandom_range(0, 1));
        a_d_req   = 1'($urandom_range(0, 1));
        a_d_we    = 1'($urandom_range(0, 1));
        a_if_addr = 5'd3;  a_d_addr = 5'd6;  a_d_wdata = 16'h5555;
        b_if_req  = 1'b0;  b_d_req = 1'b0;   b_d_we = 1'b0;
        b_if_addr = 5'd0;  b_d_addr = 5'd0;  b_d_wdata = 16'h0000;
        repeat (3) tick();

        // reset state with requests toggling
        chk("rst_write_n", a_mem_write_n, 1'b1);
        chk("rst_read_n",  a_mem_read_n,  1'b1);
        chk("rst_busy",    a_busy,        1'b0);
        chk("rst_acks",    {a_if_ack, a_d_ack}, 2'b00);
        chk("rst_rdata",   {a_if_rdata, a_d_rdata}, 32'h0);
        chk("rst_mem_bus", {a_mem_addr, a_mem_in}, 21'h0);

        a_if_req = 1'b0;
        a_d_req  = 1'b0;
        #3 proc_rst = 1'b1;
        tick();
        tick();
        chk("idle_busy",    a_busy, 1'b0);
        chk("idle_strobes", {a_mem_write_n, a_mem_read_n}, 2'b11);

        // round-robin contention from reset: IF, D, IF, D
        a_if_addr = 5'd1; a_d_addr = 5'd2; a_d_we = 1'b0;
        a_if_req  = 1'b1; a_d_req  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("rr_addr",    a_mem_addr, (g % 2 == 0) ? 5'd1 : 5'd2);
            chk("rr_strobes", {a_mem_write_n, a_mem_read_n}, 2'b10);
            chk("rr_busy",    a_busy, 1'b1);
            tick();
            chk("rr_ack", {a_if_ack, a_d_ack}, (g % 2 == 0) ? 2'b10 : 2'b01);
            if (g % 2 == 0) chk("rr_if_rdata", a_if_rdata, 16'hB001);
            else            chk("rr_d_rdata",  a_d_rdata,  16'hB002);
            tick();
            chk("rr_ack_off", {a_if_ack, a_d_ack}, 2'b00);
            chk("rr_idle",    a_busy, 1'b0);
        end
        a_if_req = 1'b0;
        a_d_req  = 1'b0;
        tick();

        // data write to 7
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 5'd7; a_d_wdata = 16'hA5C3;
        tick();
        chk("wr_strobes", {a_mem_write_n, a_mem_read_n}, 2'b01);
        chk("wr_addr",    a_mem_addr, 5'd7);
        chk("wr_data",    a_mem_in,   16'hA5C3);
        chk("wr_no_ack",  a_d_ack,    1'b0);
        a_d_req = 1'b0;
        tick();
        chk("wr_strobe_off", {a_mem_write_n, a_mem_read_n}, 2'b11);
        chk("wr_ack",        {a_if_ack, a_d_ack}, 2'b01);
        chk("wr_d_rdata",    a_d_rdata, 16'hB002);
        tick();
        chk("wr_ack_off", a_d_ack, 1'b0);
        chk("wr_mem7",    mem_a[7], 16'hA5C3);

        // fetch of word 7
        a_if_req = 1'b1; a_if_addr = 5'd7;
        tick();
        chk("fe_strobes", {a_mem_write_n, a_mem_read_n}, 2'b10);
        a_if_req = 1'b0;
        tick();
        chk("fe_ack",   a_if_ack,   1'b1);
        chk("fe_rdata", a_if_rdata, 16'hA5C3);
        tick();
        chk("fe_ack_off", a_if_ack,   1'b0);
        chk("fe_hold",    a_if_rdata, 16'hA5C3);

        // inputs changed mid-access are ignored
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 5'd3; a_d_wdata = 16'h3C3C;
        tick();
        chk("mid_addr", a_mem_addr, 5'd3);
        a_d_addr = 5'd9; a_d_wdata = 16'h9999; a_d_req = 1'b0;
        tick();
        chk("mid_ack", a_d_ack, 1'b1);
        tick();
        chk("mid_mem3", mem_a[3], 16'h3C3C);
        chk("mid_mem9", mem_a[9], 16'hB009);

        // reset during write access to word 4
        a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 5'd4; a_d_wdata = 16'hFFFF;
        tick();
        chk("rm_write_n_low", a_mem_write_n, 1'b0);
        #1 proc_rst = 1'b0;
        #1;
        chk("rm_write_n_high", a_mem_write_n, 1'b1);
        chk("rm_busy",         a_busy,        1'b0);
        a_d_req = 1'b0;
        @(negedge clk);
        #2 proc_rst = 1'b1;
        tick();
        chk("rm_no_ack", {a_if_ack, a_d_ack}, 2'b00);
        chk("rm_mem4",   mem_a[4], 16'h1111);
        a_if_req = 1'b1; a_if_addr = 5'd4;
        tick();
        a_if_req = 1'b0;
        tick();
        chk("rm_fetch4", a_if_rdata, 16'h1111);
        tick();

        // data-priority contention
        b_if_addr = 5'd1; b_d_addr = 5'd2; b_d_we = 1'b0;
        b_if_req  = 1'b1; b_d_req  = 1'b1;
        for (int g = 0; g < 2; g++) begin
            tick();
            chk("dp_addr", b_mem_addr, 5'd2);
            tick();
            chk("dp_ack",   {b_if_ack, b_d_ack}, 2'b01);
            chk("dp_rdata", b_d_rdata, 16'hB002);
            tick();
            chk("dp_ack_off", {b_if_ack, b_d_ack}, 2'b00);
        end
        b_d_req = 1'b0;
        tick();
        chk("dp_if_addr", b_mem_addr, 5'd1);
        b_if_req = 1'b0;
        tick();
        chk("dp_if_ack",   {b_if_ack, b_d_ack}, 2'b10);
        chk("dp_if_rdata", b_if_rdata, 16'hB001);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
